// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges ALU and load write-backs into the register file's single write port.
// Two 2-entry FIFOs feed one registered write stage and drive a per-register pending bitmap.
// Build option: define WB_RR_EN for round-robin arbitration; otherwise the ALU (A) has fixed priority.

module wb_port_fifo #(
    parameter int D_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [2:0]        dest_i,
    input  logic [D_SIZE-1:0] data_i,
    input  logic              pop_i,
    output logic              ready_o,
    output logic              empty_o,
    output logic [2:0]        head_dest_o,
    output logic [D_SIZE-1:0] head_data_o,
    output logic [7:0]        mask_o
);
    logic [2:0]        dest_q [2];
    logic [D_SIZE-1:0] data_q [2];
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        live;

    assign ready_o     = cnt_q != 2'd2;
    assign empty_o     = cnt_q == 2'd0;
    assign head_dest_o = dest_q[rd_q];
    assign head_data_o = data_q[rd_q];

    // Pointer/count next state and the one-hot destinations of the entries currently held.
    always_comb begin
        rd_d    = rd_q ^ pop_i;
        wr_d    = wr_q ^ push_i;
        cnt_d   = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        live[0] = (cnt_q == 2'd2) | ((cnt_q == 2'd1) & ~rd_q);
        live[1] = (cnt_q == 2'd2) | ((cnt_q == 2'd1) & rd_q);
        mask_o  = (live[0] ? 8'b1 << dest_q[0] : 8'd0) | (live[1] ? 8'b1 << dest_q[1] : 8'd0);
    end

    // Storage and pointers; reset discards all contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            cnt_q     <= 2'd0;
            dest_q[0] <= 3'd0;
            dest_q[1] <= 3'd0;
            data_q[0] <= '0;
            data_q[1] <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (push_i) begin
                dest_q[wr_q] <= dest_i;
                data_q[wr_q] <= data_i;
            end
        end
    end
endmodule

module wb_port_arbiter #(
    parameter int D_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_dest,
    input  logic [D_SIZE-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [2:0]        b_dest,
    input  logic [D_SIZE-1:0] b_data,
    output logic              r2_write_en,
    output logic [2:0]        r2_destination,
    output logic [D_SIZE-1:0] write_back,
    output logic [7:0]        pending
);
    logic              a_empty, b_empty, grant_a, grant_b;
    logic [2:0]        a_hdest, b_hdest;
    logic [D_SIZE-1:0] a_hdata, b_hdata;
    logic [7:0]        a_mask, b_mask;
    logic              en_q, en_d;
    logic [2:0]        dest_q, dest_d;
    logic [D_SIZE-1:0] data_q, data_d;

    wb_port_fifo #(.D_SIZE(D_SIZE)) u_fifo_a (
        .clk(clk), .rst_n(rst_n), .push_i(a_valid & a_ready), .dest_i(a_dest), .data_i(a_data),
        .pop_i(grant_a), .ready_o(a_ready), .empty_o(a_empty), .head_dest_o(a_hdest),
        .head_data_o(a_hdata), .mask_o(a_mask)
    );

    wb_port_fifo #(.D_SIZE(D_SIZE)) u_fifo_b (
        .clk(clk), .rst_n(rst_n), .push_i(b_valid & b_ready), .dest_i(b_dest), .data_i(b_data),
        .pop_i(grant_b), .ready_o(b_ready), .empty_o(b_empty), .head_dest_o(b_hdest),
        .head_data_o(b_hdata), .mask_o(b_mask)
    );

`ifdef WB_RR_EN
    logic rr_q, rr_d;

    // Round-robin: the pointer (0 = A) breaks ties and flips to the other producer after any grant.
    always_comb begin
        grant_a = ~a_empty & (b_empty | ~rr_q);
        grant_b = ~b_empty & (a_empty | rr_q);
        rr_d    = grant_a ? 1'b1 : grant_b ? 1'b0 : rr_q;
    end

    // Tie-break pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 1'b0;
        else        rr_q <= rr_d;
    end
`else
    // Fixed priority: A wins whenever its FIFO has an entry.
    always_comb begin
        grant_a = ~a_empty;
        grant_b = a_empty & ~b_empty;
    end
`endif

    // Output stage loads the granted head; without a grant only the enable drops.
    always_comb begin
        en_d   = grant_a | grant_b;
        dest_d = grant_a ? a_hdest : grant_b ? b_hdest : dest_q;
        data_d = grant_a ? a_hdata : grant_b ? b_hdata : data_q;
    end

    // Registered write port; reset discards any in-flight write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            dest_q <= 3'd0;
            data_q <= '0;
        end else begin
            en_q   <= en_d;
            dest_q <= dest_d;
            data_q <= data_d;
        end
    end

    assign r2_write_en    = en_q;
    assign r2_destination = dest_q;
    assign write_back     = data_q;
    assign pending        = a_mask | b_mask | (en_q ? 8'b1 << dest_q : 8'd0);
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: queue-based model of the write-back arbiter checked every cycle, plus directed literal checks.
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [2:0]  a_dest = 3'd0, b_dest = 3'd0;
    logic [31:0] a_data = 32'd0, b_data = 32'd0;
    logic        r2_write_en;
    logic [2:0]  r2_destination;
    logic [31:0] write_back;
    logic [7:0]  pending;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct packed { logic [2:0] d; logic [31:0] v; } ent_t;
    ent_t        qa[$];
    ent_t        qb[$];
    logic        m_en = 1'b0;
    logic [2:0]  m_dest = 3'd0;
    logic [31:0] m_data = 32'd0;
`ifdef WB_RR_EN
    logic        m_rr = 1'b0;
`endif

    logic [2:0]  log_d[$];
    logic [31:0] log_v[$];
    int          log_c[$];

    wb_port_arbiter #(.D_SIZE(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
        .r2_write_en(r2_write_en), .r2_destination(r2_destination),
        .write_back(write_back), .pending(pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] ad, input logic [31:0] adt,
                         input logic bv, input logic [2:0] bd, input logic [31:0] bdt);
        a_valid = av; a_dest = ad; a_data = adt;
        b_valid = bv; b_dest = bd; b_data = bdt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic clear_log();
        log_d.delete(); log_v.delete(); log_c.delete();
    endtask

    // Behavioural model: two queues, one write per edge, taken from the head chosen by the policy.
    initial begin
        ent_t e;
        bit   ga, gb, acc_a, acc_b;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                qa.delete(); qb.delete();
                m_en = 1'b0; m_dest = 3'd0; m_data = 32'd0;
`ifdef WB_RR_EN
                m_rr = 1'b0;
`endif
            end else begin
                acc_a = a_valid && qa.size() < 2;
                acc_b = b_valid && qb.size() < 2;
                ga = 0; gb = 0;
                if (qa.size() > 0 && qb.size() > 0) begin
`ifdef WB_RR_EN
                    if (m_rr) gb = 1; else ga = 1;
`else
                    ga = 1;
`endif
                end else if (qa.size() > 0) ga = 1;
                else if (qb.size() > 0) gb = 1;
                if (ga) begin
                    e = qa.pop_front(); m_en = 1'b1; m_dest = e.d; m_data = e.v;
`ifdef WB_RR_EN
                    m_rr = 1'b1;
`endif
                end else if (gb) begin
                    e = qb.pop_front(); m_en = 1'b1; m_dest = e.d; m_data = e.v;
`ifdef WB_RR_EN
                    m_rr = 1'b0;
`endif
                end else m_en = 1'b0;
                if (acc_a) begin e.d = a_dest; e.v = a_data; qa.push_back(e); end
                if (acc_b) begin e.d = b_dest; e.v = b_data; qb.push_back(e); end
            end
        end
    end

    // Every-cycle comparison against the model, and a log of register-file writes.
    always @(negedge clk) begin
        logic [7:0] mp;
        mp = m_en ? 8'b1 << m_dest : 8'd0;
        foreach (qa[i]) mp[qa[i].d] = 1'b1;
        foreach (qb[i]) mp[qb[i].d] = 1'b1;
        check("model a_ready", a_ready, qa.size() < 2);
        check("model b_ready", b_ready, qb.size() < 2);
        check("model r2_write_en", r2_write_en, m_en);
        check("model r2_destination", r2_destination, m_dest);
        check("model write_back", write_back, m_data);
        check("model pending", pending, mp);
        if (r2_write_en === 1'b1) begin
            log_d.push_back(r2_destination); log_v.push_back(write_back); log_c.push_back(cyc);
        end
    end

    initial begin
        logic [2:0] bl [3];
        logic [2:0] bseen [$];
        logic [31:0] bval [$];
        int bi;
        logic rdy, bv;
        bl[0] = 3'd1; bl[1] = 3'd2; bl[2] = 3'd4;

        repeat (2) @(posedge clk);
        #1;
        check("reset r2_write_en", r2_write_en, 0);
        check("reset r2_destination", r2_destination, 0);
        check("reset write_back", write_back, 0);
        check("reset pending", pending, 0);
        check("reset a_ready", a_ready, 1);
        check("reset b_ready", b_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        drive(1'b1, 3'd3, 32'h11, 1'b0, 3'd0, 32'd0);
        check("single pending k", pending, 8'h08);
        check("single en k", r2_write_en, 0);
        idle(1);
        check("single en k+1", r2_write_en, 1);
        check("single dest k+1", r2_destination, 3);
        check("single data k+1", write_back, 32'h11);
        check("single pending k+1", pending, 8'h08);
        idle(1);
        check("single en k+2", r2_write_en, 0);
        check("single pending k+2", pending, 8'h00);
        check("single dest held", r2_destination, 3);

        clear_log();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 32'h100 + 32'(i), 1'b0, 3'd0, 32'd0);
            check("stream a_ready", a_ready, 1);
        end
        idle(3);
        check("stream count", log_d.size(), 8);
        for (int i = 0; i < 8 && i < log_d.size(); i++) begin
            check("stream dest", log_d[i], i);
            check("stream data", log_v[i], 32'h100 + i);
            check("stream back-to-back", log_c[i] - log_c[0], i);
        end

        clear_log();
        drive(1'b1, 3'd2, 32'hA2, 1'b1, 3'd2, 32'hB2);
        check("overlap pending 1", pending, 8'h04);
        idle(1);
        check("overlap pending 2", pending, 8'h04);
        idle(1);
        check("overlap pending 3", pending, 8'h04);
        idle(1);
        check("overlap pending clear", pending, 8'h00);
        check("overlap count", log_d.size(), 2);
        if (log_d.size() == 2) begin
            check("overlap dest 0", log_d[0], 2);
            check("overlap dest 1", log_d[1], 2);
`ifdef WB_RR_EN
            check("overlap first data", log_v[0], 32'hB2);
`else
            check("overlap first data", log_v[0], 32'hA2);
`endif
        end

        clear_log();
        bi = 0;
        for (int c = 0; c < 8; c++) begin
            rdy = b_ready;
            bv = bi < 3;
            drive(1'b1, 3'd5 + 3'(c % 2), 32'h500 + 32'(c), bv, bv ? bl[bi] : 3'd0, 32'hB00 + 32'(bi));
            if (bv && rdy) begin
                bi++;
`ifndef WB_RR_EN
                if (bi == 2) check("full b_ready low", b_ready, 0);
`endif
            end
        end
        for (int t = 0; t < 10 && bi < 3; t++) begin
            rdy = b_ready;
            drive(1'b0, 3'd0, 32'd0, 1'b1, bl[bi], 32'hB00 + 32'(bi));
            if (rdy) bi++;
        end
        check("full all B accepted", bi, 3);
        idle(6);
        foreach (log_d[i]) if (log_d[i] < 3'd5) begin bseen.push_back(log_d[i]); bval.push_back(log_v[i]); end
        check("full B count", bseen.size(), 3);
        for (int i = 0; i < 3 && i < bseen.size(); i++) begin
            check("full B order", bseen[i], bl[i]);
            check("full B data", bval[i], 32'hB00 + i);
        end
`ifndef WB_RR_EN
        check("full total writes", log_d.size(), 11);
        if (log_d.size() == 11) check("full B after A", log_d[8], 1);
`endif

        drive(1'b1, 3'd0, 32'hC0, 1'b1, 3'd1, 32'hC1);
        drive(1'b1, 3'd2, 32'hC2, 1'b1, 3'd3, 32'hC3);
        drive(1'b1, 3'd4, 32'hC4, 1'b1, 3'd5, 32'hC5);
        check("traffic en before reset", r2_write_en, 1);
        a_valid = 1'b0; b_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async reset en", r2_write_en, 0);
        check("async reset pending", pending, 0);
        check("async reset a_ready", a_ready, 1);
        check("async reset b_ready", b_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        clear_log();
        @(posedge clk);
        #1;
        idle(4);
        check("no write after reset", log_d.size(), 0);

        clear_log();
        drive(1'b1, 3'd5, 32'h55, 1'b1, 3'd0, 32'h50);
        drive(1'b1, 3'd6, 32'h66, 1'b1, 3'd7, 32'h57);
        idle(5);
        check("rr count", log_d.size(), 4);
        if (log_d.size() == 4) begin
`ifdef WB_RR_EN
            check("rr order", {log_d[0], log_d[1], log_d[2], log_d[3]}, {3'd5, 3'd0, 3'd6, 3'd7});
`else
            check("rr order", {log_d[0], log_d[1], log_d[2], log_d[3]}, {3'd5, 3'd6, 3'd0, 3'd7});
`endif
            check("rr no idle", log_c[3] - log_c[0], 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
